// File: rtl/tug_pkg.sv
// Shared definitions for the tug-of-war match controller: state encoding,
// parameter defaults and the tick counter width.
package tug_pkg;

    localparam int WAIT_TICKS_DEF    = 2;
    localparam int GLOAT_TICKS_DEF   = 2;
    localparam int ROUNDS_TO_WIN_DEF = 3;
    localparam int SCORE_W_DEF       = 4;

    // Tick targets are limited to 1..15, so four bits always suffice.
    localparam int TICK_W = 4;

    localparam logic [2:0] ST_RESET     = 3'd0;
    localparam logic [2:0] ST_WAIT      = 3'd1;
    localparam logic [2:0] ST_DARK      = 3'd2;
    localparam logic [2:0] ST_PLAY      = 3'd3;
    localparam logic [2:0] ST_GLOAT     = 3'd4;
    localparam logic [2:0] ST_MATCH_END = 3'd5;

    typedef enum logic [2:0] {
        S_RESET     = ST_RESET,
        S_WAIT      = ST_WAIT,
        S_DARK      = ST_DARK,
        S_PLAY      = ST_PLAY,
        S_GLOAT     = ST_GLOAT,
        S_MATCH_END = ST_MATCH_END
    } state_e;

endpackage

// File: rtl/tug_tick_cnt.sv
// Slow-tick pulse counter: counts enabled pulses and flags the TARGET-th one.
// done is combinational so the owner can act on the same edge that samples
// the final pulse; clr wins over en so a state change always restarts at 0.
module tug_tick_cnt
    import tug_pkg::*;
#(
    parameter int TARGET = 2,
    parameter int CNT_W  = TICK_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TARGET - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear on request, otherwise advance on each enabled pulse.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = en && (cnt_q == LAST);

endmodule

// File: rtl/tug_match_ctrl.sv
// Tug-of-war match controller: sequences WAIT/DARK/PLAY/GLOAT rounds, keeps
// per-side saturating scores and declares the match winner.
module tug_match_ctrl
    import tug_pkg::*;
#(
    parameter int WAIT_TICKS    = WAIT_TICKS_DEF,
    parameter int GLOAT_TICKS   = GLOAT_TICKS_DEF,
    parameter int ROUNDS_TO_WIN = ROUNDS_TO_WIN_DEF,
    parameter int SCORE_W       = SCORE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               slowen,
    input  logic               rout,
    input  logic               winrnd,
    input  logic               win_side,
    input  logic               new_match,
    output logic               clear,
    output logic               leds_on,
    output logic [1:0]         led_control,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               match_over,
    output logic               match_winner
);

    localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(ROUNDS_TO_WIN);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;
    logic               winner_q, winner_d;
    logic               wait_done_s, gloat_done_s;
    logic               state_chg_s;

    // Any state change is a state entry, so both counters restart from 0.
    assign state_chg_s = (state_d != state_q);

    tug_tick_cnt #(.TARGET(WAIT_TICKS), .CNT_W(TICK_W)) u_wait_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_chg_s),
        .en   (slowen && (state_q == S_WAIT)),
        .done (wait_done_s)
    );

    tug_tick_cnt #(.TARGET(GLOAT_TICKS), .CNT_W(TICK_W)) u_gloat_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_chg_s),
        .en   (slowen && (state_q == S_GLOAT)),
        .done (gloat_done_s)
    );

    // Next-state, score and winner logic; round wins beat the random expiry.
    always_comb begin
        state_d   = state_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        winner_d  = winner_q;
        case (state_q)
            S_RESET: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_done_s) begin
                    state_d = S_DARK;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DARK, S_PLAY: begin
                if (winrnd) begin
                    state_d = S_GLOAT;
                    if (win_side) begin
                        if (score_r_q < WIN_SCORE) begin
                            score_r_d = score_r_q + SCORE_W'(1);
                        end else begin
                            score_r_d = score_r_q;
                        end
                    end else begin
                        if (score_l_q < WIN_SCORE) begin
                            score_l_d = score_l_q + SCORE_W'(1);
                        end else begin
                            score_l_d = score_l_q;
                        end
                    end
                end else if ((state_q == S_DARK) && slowen && rout) begin
                    state_d = S_PLAY;
                end else begin
                    state_d = state_q;
                end
            end
            S_GLOAT: begin
                if (gloat_done_s) begin
                    if ((score_l_q == WIN_SCORE) || (score_r_q == WIN_SCORE)) begin
                        state_d  = S_MATCH_END;
                        winner_d = (score_r_q == WIN_SCORE);
                    end else begin
                        state_d = S_DARK;
                    end
                end else begin
                    state_d = S_GLOAT;
                end
            end
            S_MATCH_END: begin
                if (new_match) begin
                    state_d   = S_WAIT;
                    score_l_d = {SCORE_W{1'b0}};
                    score_r_d = {SCORE_W{1'b0}};
                    winner_d  = 1'b0;
                end else begin
                    state_d = S_MATCH_END;
                end
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    // State, score and winner registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RESET;
            score_l_q <= {SCORE_W{1'b0}};
            score_r_q <= {SCORE_W{1'b0}};
            winner_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            winner_q  <= winner_d;
        end
    end

    // Moore decode of the state register for the playfield controls.
    always_comb begin
        led_control = 2'b10;
        leds_on     = 1'b1;
        clear       = 1'b1;
        match_over  = 1'b0;
        case (state_q)
            S_RESET, S_WAIT: begin
                led_control = 2'b11;
            end
            S_DARK: begin
                led_control = 2'b00;
                leds_on     = 1'b0;
                clear       = 1'b0;
            end
            S_PLAY: begin
                clear = 1'b0;
            end
            S_MATCH_END: begin
                match_over = 1'b1;
            end
            default: begin
                led_control = 2'b10;
            end
        endcase
    end

    assign score_l      = score_l_q;
    assign score_r      = score_r_q;
    assign match_winner = winner_q;

endmodule

// File: tb/tb_tug_match_ctrl.sv
// Directed bench for tug_match_ctrl: default instance plus a
// WAIT_TICKS=5 / GLOAT_TICKS=1 instance.
module tb_tug_match_ctrl;
    import tug_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, slowen, rout, winrnd, win_side, new_match;
    logic       clear, leds_on, match_over, match_winner;
    logic [1:0] led_control;
    logic [3:0] score_l, score_r;

    logic       rst2, slowen2, rout2, winrnd2, win_side2, new_match2;
    logic       clear2, leds_on2, match_over2, match_winner2;
    logic [1:0] led_control2;
    logic [3:0] score_l2, score_r2;

    int n_pass   = 0;
    int n_checks = 0;

    tug_match_ctrl dut (
        .clk(clk), .rst(rst), .slowen(slowen), .rout(rout), .winrnd(winrnd),
        .win_side(win_side), .new_match(new_match), .clear(clear),
        .leds_on(leds_on), .led_control(led_control), .score_l(score_l),
        .score_r(score_r), .match_over(match_over), .match_winner(match_winner)
    );

    tug_match_ctrl #(.WAIT_TICKS(5), .GLOAT_TICKS(1)) dut2 (
        .clk(clk), .rst(rst2), .slowen(slowen2), .rout(rout2), .winrnd(winrnd2),
        .win_side(win_side2), .new_match(new_match2), .clear(clear2),
        .leds_on(leds_on2), .led_control(led_control2), .score_l(score_l2),
        .score_r(score_r2), .match_over(match_over2), .match_winner(match_winner2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_slow();
        slowen = 1'b1;
        tick();
        slowen = 1'b0;
    endtask

    task automatic chk_st(input string tag, input logic [2:0] exp);
        chk(tag, 32'(dut.state_q), 32'(exp));
    endtask

    task automatic chk_out(input string tag, input logic c, input logic l, input logic [1:0] lc);
        chk({tag, "_clear"}, 32'(clear), 32'(c));
        chk({tag, "_leds"}, 32'(leds_on), 32'(l));
        chk({tag, "_ledctl"}, 32'(led_control), 32'(lc));
    endtask

    initial begin
        rst = 1'b1; slowen = 1'b0; rout = 1'b0; winrnd = 1'b0; win_side = 1'b0; new_match = 1'b0;
        rst2 = 1'b1; slowen2 = 1'b0; rout2 = 1'b0; winrnd2 = 1'b0; win_side2 = 1'b0; new_match2 = 1'b0;

        // Power-up
        tick(); tick(); tick();
        chk_st("reset_state", ST_RESET);
        chk_out("reset_out", 1'b1, 1'b1, 2'b11);
        chk("reset_mo", 32'(match_over), 32'd0);
        chk("reset_mw", 32'(match_winner), 32'd0);
        chk("reset_sl", 32'(score_l), 32'd0);
        chk("reset_sr", 32'(score_r), 32'd0);
        rst = 1'b0;
        tick();
        chk_st("wait_entry", ST_WAIT);
        pulse_slow();
        chk_st("wait_after_1", ST_WAIT);
        pulse_slow();
        chk_st("dark_entry", ST_DARK);
        chk_out("dark_out", 1'b0, 1'b0, 2'b00);

        // Simultaneous winrnd/slowen/rout in DARK: round win takes priority
        winrnd = 1'b1; slowen = 1'b1; rout = 1'b1; win_side = 1'b1;
        tick();
        winrnd = 1'b0; slowen = 1'b0; rout = 1'b0;
        chk_st("prio_gloat", ST_GLOAT);
        chk("prio_sr", 32'(score_r), 32'd1);
        chk("prio_sl", 32'(score_l), 32'd0);
        chk_out("gloat_out", 1'b1, 1'b1, 2'b10);

        // winrnd in GLOAT is ignored
        winrnd = 1'b1; tick(); winrnd = 1'b0;
        chk("gloat_winrnd_sr", 32'(score_r), 32'd1);
        chk_st("gloat_hold", ST_GLOAT);
        pulse_slow();
        chk_st("gloat_after_1", ST_GLOAT);
        pulse_slow();
        chk_st("gloat_to_dark", ST_DARK);

        // Round 2 through PLAY, with a stray new_match in PLAY
        slowen = 1'b1; rout = 1'b1; tick(); slowen = 1'b0; rout = 1'b0;
        chk_st("play_entry", ST_PLAY);
        chk_out("play_out", 1'b0, 1'b1, 2'b10);
        new_match = 1'b1; tick(); new_match = 1'b0;
        chk_st("play_newmatch", ST_PLAY);
        chk("play_newmatch_sr", 32'(score_r), 32'd1);
        winrnd = 1'b1; tick(); winrnd = 1'b0;
        chk("round2_sr", 32'(score_r), 32'd2);
        pulse_slow(); pulse_slow();
        chk_st("round2_dark", ST_DARK);

        // Round 3 wins the match for the right side
        slowen = 1'b1; rout = 1'b1; tick(); slowen = 1'b0; rout = 1'b0;
        winrnd = 1'b1; tick(); winrnd = 1'b0;
        chk("round3_sr", 32'(score_r), 32'd3);
        pulse_slow();
        chk("round3_mo_early", 32'(match_over), 32'd0);
        pulse_slow();
        chk_st("match_end", ST_MATCH_END);
        chk("match_mo", 32'(match_over), 32'd1);
        chk("match_mw", 32'(match_winner), 32'd1);
        chk_out("match_out", 1'b1, 1'b1, 2'b10);
        winrnd = 1'b1; tick(); tick(); winrnd = 1'b0;
        chk("match_sat_sr", 32'(score_r), 32'd3);
        chk_st("match_hold", ST_MATCH_END);
        new_match = 1'b1; tick(); new_match = 1'b0;
        chk_st("newmatch_wait", ST_WAIT);
        chk("newmatch_sl", 32'(score_l), 32'd0);
        chk("newmatch_sr", 32'(score_r), 32'd0);
        chk("newmatch_mo", 32'(match_over), 32'd0);

        // Left side to 2, then reset mid-GLOAT
        pulse_slow(); pulse_slow();
        win_side = 1'b0;
        winrnd = 1'b1; tick(); winrnd = 1'b0;
        chk("left1_sl", 32'(score_l), 32'd1);
        pulse_slow(); pulse_slow();
        winrnd = 1'b1; tick(); winrnd = 1'b0;
        chk("left2_sl", 32'(score_l), 32'd2);
        pulse_slow();
        chk("gloat_cnt_mid", 32'(dut.u_gloat_cnt.cnt_q), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_st("midrst_state", ST_RESET);
        chk("midrst_sl", 32'(score_l), 32'd0);
        chk("midrst_sr", 32'(score_r), 32'd0);
        chk("midrst_cnt", 32'(dut.u_gloat_cnt.cnt_q), 32'd0);
        chk("midrst_mw", 32'(match_winner), 32'd0);
        tick();
        chk_st("midrst_wait", ST_WAIT);
        pulse_slow();
        chk_st("midrst_wait_1", ST_WAIT);
        pulse_slow();
        chk_st("midrst_dark", ST_DARK);

        // Second instance: WAIT_TICKS=5, GLOAT_TICKS=1
        rst2 = 1'b0; tick();
        chk("d2_wait", 32'(dut2.state_q), 32'(ST_WAIT));
        for (int i = 0; i < 4; i++) begin
            slowen2 = 1'b1; tick(); slowen2 = 1'b0; tick();
        end
        chk("d2_wait_after_4", 32'(dut2.state_q), 32'(ST_WAIT));
        slowen2 = 1'b1; tick(); slowen2 = 1'b0;
        chk("d2_dark_on_5", 32'(dut2.state_q), 32'(ST_DARK));
        winrnd2 = 1'b1; win_side2 = 1'b0; tick(); winrnd2 = 1'b0;
        chk("d2_gloat", 32'(dut2.state_q), 32'(ST_GLOAT));
        chk("d2_sl", 32'(score_l2), 32'd1);
        slowen2 = 1'b1; tick(); slowen2 = 1'b0;
        chk("d2_gloat_exit_1", 32'(dut2.state_q), 32'(ST_DARK));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tug_match_ctrl.md
TUG_MATCH_CTRL -- requirements
Module: tug_match_ctrl

Interface
REQ-001 Parameter WAIT_TICKS, default 2: slowen pulses spent in WAIT before first DARK; legal range 1..15.
REQ-002 Parameter GLOAT_TICKS, default 2: slowen pulses spent in GLOAT after each round; legal range 1..15.
REQ-003 Parameter ROUNDS_TO_WIN, default 3: round wins needed to take the match; legal range 1..(2**SCORE_W)-1.
REQ-004 Parameter SCORE_W, default 4: width of each score counter.
REQ-005 clk  in  1  single system clock; all state updates occur on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 slowen  in  1  one-cycle slow-tick enable pulse.
REQ-008 rout  in  1  random-delay expiry; qualified by slowen.
REQ-009 winrnd  in  1  round-won pulse from the playfield.
REQ-010 win_side  in  1  round winner, valid with winrnd: 0 = left, 1 = right.
REQ-011 new_match  in  1  one-cycle request to start a new match from MATCH_END.
REQ-012 clear  out  1  playfield clear.
REQ-013 leds_on  out  1  playfield LED enable.
REQ-014 led_control  out  2  LED mode select.
REQ-015 score_l, score_r  out  SCORE_W  round wins per side.
REQ-016 match_over  out  1  high while in MATCH_END.
REQ-017 match_winner  out  1  side that reached ROUNDS_TO_WIN; valid while match_over is high.

Function
REQ-018 States: RESET, WAIT, DARK, PLAY, GLOAT, MATCH_END, held in a registered state variable updated on the rising edge of clk.
REQ-019 RESET goes to WAIT on the first clock with rst low.
REQ-020 WAIT goes to DARK on the clock that samples the WAIT_TICKS-th slowen pulse counted while in WAIT.
REQ-021 DARK: winrnd goes to GLOAT; else slowen&&rout goes to PLAY; else stay; winrnd has priority on simultaneous events.
REQ-022 PLAY goes to GLOAT on winrnd; otherwise stay.
REQ-023 On a winrnd accepted in DARK or PLAY, the score for win_side increments by 1 on the same edge as the GLOAT transition; winrnd in any other state is ignored and changes no score.
REQ-024 Scores saturate at ROUNDS_TO_WIN and never wrap.
REQ-025 GLOAT, on the clock that samples the GLOAT_TICKS-th slowen pulse: go to MATCH_END if either score equals ROUNDS_TO_WIN, else go to DARK.
REQ-026 MATCH_END holds until new_match, then goes to WAIT with both scores cleared on the same edge.
REQ-027 new_match in any state other than MATCH_END is ignored.
REQ-028 The tick counter clears on every state entry and counts only slowen pulses sampled while in WAIT or GLOAT.
REQ-029 Outputs are a Moore decode of the state register, with zero-cycle latency from state:
- led_control[0] = 1 only in RESET or WAIT.
- led_control[1] = 0 only in DARK.
- leds_on = 0 only in DARK.
- clear = 0 only in DARK or PLAY.
REQ-030 match_winner is registered on entry to MATCH_END and holds its value until the next reset or new_match.
REQ-031 Any unused state encoding goes to RESET on the next clock.

Reset
REQ-032 rst high at a rising edge forces the following, regardless of current state, including mid-round or mid-GLOAT:
- state = RESET
- score_l = score_r = 0
- tick counter = 0
- match_winner = 0
REQ-033 Output values while in RESET: clear=1, leds_on=1, led_control=2'b11, match_over=0.

Structure
REQ-034 Shared package tug_pkg holds:
- the state encoding localparams
- the default values of WAIT_TICKS, GLOAT_TICKS, ROUNDS_TO_WIN and SCORE_W.
REQ-035 One sub-module, tug_tick_cnt: a slowen pulse counter with a synchronous clear, a parameter TARGET, and a done output that is high on the cycle the TARGET-th pulse is sampled.
REQ-036 The state machine, score registers and output decode reside in tug_match_ctrl.

Verification
REQ-037 Power-up: rst high 3 cycles, then low; with 2 slowen pulses -> RESET, WAIT, DARK; clear=0, leds_on=0, led_control=2'b00 in DARK.
REQ-038 In DARK, winrnd, slowen and rout all high in the same cycle with win_side=1 -> next state GLOAT (not PLAY); score_r=1.
REQ-039 Three right-side round wins with ROUNDS_TO_WIN=3 -> after the third GLOAT, MATCH_END with match_over=1, match_winner=1, score_r=3; further winrnd pulses leave score_r=3.
REQ-040 In MATCH_END, new_match pulse -> next state WAIT, scores 0/0; new_match pulsed while in PLAY -> no effect.
REQ-041 rst asserted for one cycle while in GLOAT with score_l=2 -> next state RESET, scores 0/0, tick count restarts from 0.
REQ-042 WAIT_TICKS=5, GLOAT_TICKS=1 instance -> DARK entered exactly on the 5th slowen pulse; GLOAT exits on the 1st slowen pulse.
